bit_serializer: RTL and testbench
=================================

# bit_serializer

Converts 32-bit random words back into a serial bit stream with a valid/ready handshake, MSB first, so the bit order matches the order in which `bit_collector` packed them. Sits downstream of `bit_collector` (or any word source that issues single-cycle `word_valid` pulses without backpressure) and feeds bit-level consumers such as health tests or a serial output port. A small FIFO absorbs words while the serializer drains; words that arrive while the FIFO is full are dropped and flagged.

## Interface
- `WIDTH`, 32: word width in bits.
- `DEPTH`, 2: FIFO depth in words; must be a power of two, ≥ 2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `word_in` in WIDTH: input word; sampled when `word_valid` = 1.
- `word_valid` in 1: single-cycle push strobe; there is no ready signal.
- `bit_out` out 1: current serial bit.
- `bit_valid` out 1: `bit_out` is valid.
- `bit_ready` in 1: consumer accepts `bit_out` this cycle.
- `fifo_count` out $clog2(DEPTH)+1: number of words held in the FIFO, excluding the word being shifted.
- `busy` out 1: the shift engine holds a word (state SHIFT).
- `overflow` out 1: sticky flag; at least one word was dropped.
- `ovf_clr` in 1: synchronous clear for `overflow` and `drop_cnt`.
- `drop_cnt` out 16: number of dropped words, saturating. Present only with `BIT_SER_DROP_CNT_EN`.

## Operation
- **Reset values:** FIFO empty. State IDLE. `bit_out`, `bit_valid`, `busy`, `overflow` and `fifo_count` are 0. `drop_cnt` is 0.
- **Push:** the word is written when `word_valid` = 1 and either `fifo_count` < DEPTH or a pop happens in the same cycle. Otherwise the word is dropped, `overflow` is set, and `drop_cnt` increments, saturating at 0xFFFF.
- **ovf_clr:** clears `overflow` and `drop_cnt`. If a drop happens in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- **State machine:** two states, IDLE and SHIFT. It holds a WIDTH-bit shift register `shreg` and a bit counter `bcnt` of $clog2(WIDTH) bits.
  - **IDLE:** if the FIFO is non-empty, pop the head into `shreg`, set `bcnt` = 0, and go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** `bit_valid` = 1 and `bit_out` = `shreg[WIDTH-1]`.
    - On `bit_valid && bit_ready`: shift `shreg` left by one and increment `bcnt`.
    - On the transfer with `bcnt` == WIDTH-1: if the FIFO is non-empty, pop and load the next word in the same edge and stay in SHIFT (no bubble). Otherwise go to IDLE.
- **Stability:** while `bit_valid && !bit_ready`, `bit_out`, `shreg` and `bcnt` hold.
- **Consumer side:** `bit_ready` is ignored when `bit_valid` = 0. The consumer may assert `bit_ready` permanently.
- **Simultaneous push and pop when full:** the push is accepted and `fifo_count` is unchanged.
- **Reset mid-word:** the partial word and the FIFO contents are discarded. No partial bits are emitted after reset.

## Timing
- `bit_out` and `bit_valid` are registered. No combinational path from `bit_ready` to any output.
- **Latency:** with the engine in IDLE and the FIFO empty, a push in cycle N gives `fifo_count` = 1 in N+1 and the first `bit_valid` = 1 in N+2 (`fifo_count` back to 0 in N+2).
- **Throughput:** 1 bit per cycle when `bit_ready` = 1 continuously. Consecutive words stream with no idle cycle between them.
- **Sustainable input rate:** one word per WIDTH cycles from `bit_collector` is absorbed with no drops when `bit_ready` is held at 1.
- **Register update:** `fifo_count`, `overflow` and `drop_cnt` update on the edge after the triggering event.

## Configuration
- **`BIT_SER_DROP_CNT_EN` defined:** the 16-bit saturating `drop_cnt` port and counter exist, behaving as described in Operation.
- **Macro undefined:** the `drop_cnt` port and its logic are removed. `overflow` and `ovf_clr` behave identically.

## Structure
- **Shared package `trng_pkg`:**
  - `TRNG_WORD_W` = 32, used as the default for `WIDTH`.
  - `bit_ser_state_t` enum {IDLE, SHIFT}.
  - `DROP_CNT_W` = 16.
- **Sub-module `word_fifo`:** a synchronous FIFO with WIDTH/DEPTH parameters and push, pop, full, empty and count signals. The FIFO is the natural sub-module. The FSM, shift register and drop logic stay in `bit_serializer`.

## Test plan
- **Single word:** after reset, push 0xA5000001 with `bit_ready` = 1 → first `bit_valid` 2 cycles later. Bits are 1,0,1,0,0,1,0,1, then 23 zeros, then 1, over 32 consecutive cycles. Then `bit_valid` = 0 and `busy` = 0.
- **Back-to-back:** push 0xFFFFFFFF, then 0x00000000 three cycles later, with `bit_ready` = 1 → 32 ones immediately followed by 32 zeros with no gap. `overflow` = 0.
- **Backpressure:** push 0x80000000 and hold `bit_ready` = 0 for 10 cycles once `bit_valid` rises → `bit_out` = 1 stays stable. Release `bit_ready` → the remaining 31 zeros follow.
- **Overflow:** with `bit_ready` = 0, push 4 words → the first fills the engine and the next two fill the FIFO (`fifo_count` = 2). The 4th is dropped: `overflow` = 1 and `drop_cnt` = 1. `ovf_clr` pulsed together with a 5th dropped push → `overflow` = 1 and `drop_cnt` = 1.
- **Reset mid-word:** assert `rst` after 10 bits of 0x12345678 → all outputs 0 and `fifo_count` = 0. No further bits until a new push.
- **Loopback:** chain `bit_collector` → `bit_serializer` with 1000 random bits and `bit_ready` = 1 → the output bit sequence equals the input sequence delayed (first 992 bits; the last 8 remain in the collector). `overflow` = 0.

Source files
------------

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared TRNG constants and types (word width, drop counter
//                width, serializer state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    localparam int TRNG_WORD_W = 32;
    localparam int DROP_CNT_W  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bit_ser_state_t;

endpackage : trng_pkg
`default_nettype wire

// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer_if
//  Description : Word-in / bit-out bundle of the bit serializer. The master
//                side is the word source plus bit consumer, the slave side is
//                the serializer. drop_cnt exists only with
//                BIT_SER_DROP_CNT_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if
    import trng_pkg::*;
#(
    parameter int WIDTH = TRNG_WORD_W,
    parameter int DEPTH = 2
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]      word_in;
    logic                  word_valid;
    logic                  bit_out;
    logic                  bit_valid;
    logic                  bit_ready;
    logic [CNT_W-1:0]      fifo_count;
    logic                  busy;
    logic                  overflow;
    logic                  ovf_clr;
`ifdef BIT_SER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    modport master (
        output word_in, word_valid, bit_ready, ovf_clr,
`ifdef BIT_SER_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  bit_out, bit_valid, fifo_count, busy, overflow
    );

    modport slave (
        input  word_in, word_valid, bit_ready, ovf_clr,
`ifdef BIT_SER_DROP_CNT_EN
        output drop_cnt,
`endif
        output bit_out, bit_valid, fifo_count, busy, overflow
    );

endinterface : bit_serializer_if
`default_nettype wire

// File: rtl/bit_serializer_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Small synchronous FIFO buffering words ahead of the shift
//                engine. DEPTH must be a power of two so pointers wrap
//                naturally. The caller only pops when non-empty and only
//                pushes when not full or when popping in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           wdata_i,
    input  wire logic                       pop_i,
    output logic      [WIDTH-1:0]           rdata_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH):0]     count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage array; no reset needed because count gates every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; a push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule : word_fifo
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Turns WIDTH-bit words into an MSB-first serial stream with a
//                valid/ready handshake. A word FIFO absorbs input while the
//                shift engine drains; words arriving with no room are dropped
//                and flagged through the sticky overflow bit.
//                Define BIT_SER_DROP_CNT_EN to add the 16-bit saturating
//                drop counter (drop_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
    import trng_pkg::*;
#(
    parameter int WIDTH = TRNG_WORD_W,
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bit_serializer_if.slave bus
);

    localparam int                 CNT_W     = $clog2(DEPTH) + 1;
    localparam int                 BCNT_W    = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0]  c_BCNT_LAST = BCNT_W'(WIDTH - 1);

    bit_ser_state_t      state_q;
    logic [WIDTH-1:0]    shreg_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic                bit_valid_q;
    logic                busy_q;
    logic                overflow_q;

    logic [WIDTH-1:0]    w_fifo_rdata;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_last_xfer;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Final bit of the current word is being accepted this cycle.
    assign w_last_xfer = (state_q == SHIFT) && bus.bit_ready && (bcnt_q == c_BCNT_LAST);

    // The engine takes the head either from IDLE or on the last bit (no bubble).
    assign w_pop  = !w_fifo_empty && ((state_q == IDLE) || w_last_xfer);

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = bus.word_valid && (!w_fifo_full || w_pop);
    assign w_drop = bus.word_valid && !w_push;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (bus.word_in),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Shift engine: loads words from the FIFO and emits them MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        shreg_q     <= w_fifo_rdata;
                        bcnt_q      <= '0;
                        state_q     <= SHIFT;
                        bit_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.bit_ready) begin
                        if (bcnt_q == c_BCNT_LAST) begin
                            bcnt_q <= '0;
                            if (!w_fifo_empty) begin
                                shreg_q <= w_fifo_rdata;
                            end else begin
                                // Fully shifted out, so bit_out naturally returns to 0.
                                shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
                                state_q     <= IDLE;
                                bit_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                            end
                        end else begin
                            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                            bcnt_q  <= bcnt_q + BCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    bit_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef BIT_SER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Saturating dropped-word counter; a clear coinciding with a drop restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (w_drop) begin
            if (bus.ovf_clr) begin
                drop_cnt_q <= DROP_CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (bus.ovf_clr) begin
            drop_cnt_q <= '0;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.bit_out    = shreg_q[WIDTH-1];
    assign bus.bit_valid  = bit_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = w_fifo_count;

endmodule : bit_serializer
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Directed self-checking bench for bit_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit_serializer_if #(.WIDTH(32), .DEPTH(2)) bus ();

    bit_serializer #(.WIDTH(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        bus.bit_ready  = 1'b0;
        bus.ovf_clr    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %b want 0", bus.bit_valid); end
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %b want 0", bus.bit_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", bus.fifo_count); end
`ifdef BIT_SER_DROP_CNT_EN
        checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
`endif
        bus.bit_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored: bit_valid got %b want 0", bus.bit_valid); end
    endtask

    task automatic test_single_word();
        logic [31:0] word;
        do_reset();
        word           = 32'hA500_0001;
        bus.bit_ready  = 1'b1;
        bus.word_in    = word;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        checks++; if (bus.fifo_count !== 2'd1) begin errors++; $display("FAIL single_count_n1: got %0d want 1", bus.fifo_count); end
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1: got %b want 0", bus.bit_valid); end
        tick();
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL single_count_n2: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.bit_valid !== 1'b1 || bus.bit_out !== word[31-i]) begin
                errors++;
                $display("FAIL single_bit%0d: valid/bit got %b/%b want 1/%b", i, bus.bit_valid, bus.bit_out, word[31-i]);
            end
            tick();
        end
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", bus.bit_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        int first;
        int lastc;
        int n;
        do_reset();
        got   = '0;
        first = -1;
        lastc = -1;
        n     = 0;
        bus.bit_ready = 1'b1;
        for (int c = 0; c < 75; c++) begin
            bus.word_valid = (c == 0 || c == 3);
            bus.word_in    = (c == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            tick();
            if (bus.bit_valid === 1'b1) begin
                if (first < 0) first = c;
                lastc = c;
                got   = {got[62:0], bus.bit_out};
                n++;
            end
        end
        bus.word_valid = 1'b0;
        checks++; if (first != 1) begin errors++; $display("FAIL b2b_latency: first valid after %0d edges want 1", first + 1); end
        checks++; if (n != 64) begin errors++; $display("FAIL b2b_bit_count: got %0d want 64", n); end
        checks++; if (lastc - first != 63) begin errors++; $display("FAIL b2b_gap: span got %0d want 63", lastc - first); end
        checks++; if (got !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL b2b_bits: got %h want ffffffff00000000", got); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", bus.overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.bit_ready  = 1'b0;
        bus.word_in    = 32'h8000_0000;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid/bit got %b/%b want 1/1", i, bus.bit_valid, bus.bit_out);
            end
            tick();
        end
        bus.bit_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick();
            checks++;
            if (bus.bit_valid !== 1'b1 || bus.bit_out !== 1'b0) begin
                errors++;
                $display("FAIL bp_tail%0d: valid/bit got %b/%b want 1/0", i, bus.bit_valid, bus.bit_out);
            end
        end
        tick();
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", bus.bit_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.bit_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.word_in    = 32'(k + 1);
            bus.word_valid = 1'b1;
            tick();
            if (k == 2) begin
                checks++; if (bus.fifo_count !== 2'd2) begin errors++; $display("FAIL ovf_count_full: got %0d want 2", bus.fifo_count); end
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
            end
        end
        bus.word_valid = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        checks++; if (bus.fifo_count !== 2'd2) begin errors++; $display("FAIL ovf_count_after_drop: got %0d want 2", bus.fifo_count); end
`ifdef BIT_SER_DROP_CNT_EN
        checks++; if (bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt1: got %0d want 1", bus.drop_cnt); end
`endif
        // Clear together with another drop: the drop wins.
        bus.word_in    = 32'h5555_5555;
        bus.word_valid = 1'b1;
        bus.ovf_clr    = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        bus.ovf_clr    = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_drop_wins: got %b want 1", bus.overflow); end
`ifdef BIT_SER_DROP_CNT_EN
        checks++; if (bus.drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_clr_drop_cnt: got %0d want 1", bus.drop_cnt); end
`endif
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_alone: got %b want 0", bus.overflow); end
`ifdef BIT_SER_DROP_CNT_EN
        checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_clr_cnt_zero: got %0d want 0", bus.drop_cnt); end
`endif
        // Drain 31 bits, then push while full on the final bit transfer.
        bus.bit_ready = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        bus.word_in    = 32'hDEAD_BEEF;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        checks++; if (bus.fifo_count !== 2'd2) begin errors++; $display("FAIL full_push_pop_count: got %0d want 2", bus.fifo_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf: got %b want 0", bus.overflow); end
        checks++; if (bus.bit_valid !== 1'b1) begin errors++; $display("FAIL full_push_pop_valid: got %b want 1", bus.bit_valid); end
    endtask

    task automatic test_reset_mid_word();
        int seen;
        do_reset();
        bus.bit_ready  = 1'b1;
        bus.word_in    = 32'h1234_5678;
        bus.word_valid = 1'b1;
        tick();
        bus.word_in    = 32'hCAFE_F00D;
        tick();
        bus.word_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.fifo_count !== 2'd1) begin errors++; $display("FAIL rmw_pre_count: got %0d want 1", bus.fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", bus.bit_valid); end
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL rmw_bit_out: got %b want 0", bus.bit_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b want 0", bus.busy); end
        checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("FAIL rmw_count: got %0d want 0", bus.fifo_count); end
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.bit_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmw_no_bits: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_loopback();
        logic [31:0] words [31];
        logic [31:0] acc;
        int nb;
        int widx;
        do_reset();
        for (int k = 0; k < 31; k++) words[k] = $urandom;
        acc  = '0;
        nb   = 0;
        widx = 0;
        bus.bit_ready = 1'b1;
        for (int c = 0; c < 31 * 32 + 40; c++) begin
            bus.word_valid = ((c % 32) == 0) && ((c / 32) < 31);
            if ((c / 32) < 31) bus.word_in = words[c / 32];
            tick();
            if (bus.bit_valid === 1'b1) begin
                acc = {acc[30:0], bus.bit_out};
                nb++;
                if ((nb % 32) == 0 && widx < 31) begin
                    checks++;
                    if (acc !== words[widx]) begin
                        errors++;
                        $display("FAIL loop_word%0d: got %h want %h", widx, acc, words[widx]);
                    end
                    widx++;
                end
            end
        end
        bus.word_valid = 1'b0;
        checks++; if (nb != 992) begin errors++; $display("FAIL loop_bit_count: got %0d want 992", nb); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL loop_overflow: got %b want 0", bus.overflow); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        bus.bit_ready  = 1'b0;
        bus.ovf_clr    = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_word();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bit_serializer
`default_nettype wire
